// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush/hold handling and a saturating bubble counter.
module id_ex_register #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             RegDst_ID,
    input  logic             ALUSrc_ID,
    input  logic             MemtoReg_ID,
    input  logic             RegWrite_ID,
    input  logic             MemRead_ID,
    input  logic             MemWrite_ID,
    input  logic             Branch_ID,
    input  logic             Jump_ID,
    input  logic [1:0]       ALUOp_ID,
    input  logic             Valid_ID,
    input  logic [WIDTH-1:0] PC4_ID,
    input  logic [WIDTH-1:0] ReadData1_ID,
    input  logic [WIDTH-1:0] ReadData2_ID,
    input  logic [WIDTH-1:0] SignImm_ID,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic [4:0]       Rd_ID,
    input  logic [5:0]       Funct_ID,
    input  logic [5:0]       Opcode_ID,

    input  logic             Flush,
    input  logic             Hold,

    output logic             RegDst_EX,
    output logic             ALUSrc_EX,
    output logic             MemtoReg_EX,
    output logic             RegWrite_EX,
    output logic             MemRead_EX,
    output logic             MemWrite_EX,
    output logic             Branch_EX,
    output logic             Jump_EX,
    output logic [1:0]       ALUOp_EX,
    output logic             Valid_EX,
    output logic [WIDTH-1:0] PC4_EX,
    output logic [WIDTH-1:0] ReadData1_EX,
    output logic [WIDTH-1:0] ReadData2_EX,
    output logic [WIDTH-1:0] SignImm_EX,
    output logic [4:0]       Rs_EX,
    output logic [4:0]       Rt_EX,
    output logic [4:0]       Rd_EX,
    output logic [5:0]       Funct_EX,
    output logic [5:0]       Opcode_EX,

    output logic             Stall,
    output logic [CNT_W-1:0] BubbleCount
);

    logic             r_regdst, r_alusrc, r_memtoreg, r_regwrite;
    logic             r_memread, r_memwrite, r_branch, r_jump;
    logic [1:0]       r_aluop;
    logic             r_valid;
    logic [WIDTH-1:0] r_pc4, r_rd1, r_rd2, r_imm;
    logic [4:0]       r_rs, r_rt, r_rd;
    logic [5:0]       r_funct, r_opcode;
    logic [CNT_W-1:0] r_cnt;

    logic w_haz;
    logic w_load;
    logic w_ctrl_clr;
    logic w_bubble;

    // Load in EX whose destination is a source of the instruction in ID.
    // Rt only counts as a source for R-type ALU ops and stores.
    assign w_haz = r_valid & r_memread & (r_rt != 5'd0) & Valid_ID &
                   ((r_rt == Rs_ID) |
                    ((r_rt == Rt_ID) & (~ALUSrc_ID | MemWrite_ID)));

    assign w_load     = Flush | ~Hold;
    assign w_bubble   = w_haz & ~Flush & ~Hold;
    assign w_ctrl_clr = Flush | w_haz | ~Valid_ID;
    assign Stall      = w_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regdst   <= 1'b0;
            r_alusrc   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_branch   <= 1'b0;
            r_jump     <= 1'b0;
            r_aluop    <= '0;
            r_valid    <= 1'b0;
        end else if (w_load) begin
            if (w_ctrl_clr) begin
                r_regdst   <= 1'b0;
                r_alusrc   <= 1'b0;
                r_memtoreg <= 1'b0;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
                r_branch   <= 1'b0;
                r_jump     <= 1'b0;
                r_aluop    <= '0;
                r_valid    <= 1'b0;
            end else begin
                r_regdst   <= RegDst_ID;
                r_alusrc   <= ALUSrc_ID;
                r_memtoreg <= MemtoReg_ID;
                r_regwrite <= RegWrite_ID;
                r_memread  <= MemRead_ID;
                r_memwrite <= MemWrite_ID;
                r_branch   <= Branch_ID;
                r_jump     <= Jump_ID;
                r_aluop    <= ALUOp_ID;
                r_valid    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc4    <= '0;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_imm    <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_funct  <= '0;
            r_opcode <= '0;
        end else if (w_load) begin
            r_pc4    <= PC4_ID;
            r_rd1    <= ReadData1_ID;
            r_rd2    <= ReadData2_ID;
            r_imm    <= SignImm_ID;
            r_rs     <= Rs_ID;
            r_rt     <= Rt_ID;
            r_rd     <= Rd_ID;
            r_funct  <= Funct_ID;
            r_opcode <= Opcode_ID;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_bubble && (r_cnt != '1)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign RegDst_EX    = r_regdst;
    assign ALUSrc_EX    = r_alusrc;
    assign MemtoReg_EX  = r_memtoreg;
    assign RegWrite_EX  = r_regwrite;
    assign MemRead_EX   = r_memread;
    assign MemWrite_EX  = r_memwrite;
    assign Branch_EX    = r_branch;
    assign Jump_EX      = r_jump;
    assign ALUOp_EX     = r_aluop;
    assign Valid_EX     = r_valid;
    assign PC4_EX       = r_pc4;
    assign ReadData1_EX = r_rd1;
    assign ReadData2_EX = r_rd2;
    assign SignImm_EX   = r_imm;
    assign Rs_EX        = r_rs;
    assign Rt_EX        = r_rt;
    assign Rd_EX        = r_rd;
    assign Funct_EX     = r_funct;
    assign Opcode_EX    = r_opcode;
    assign BubbleCount  = r_cnt;

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: table of ID-stage vectors plus reset and
// saturation sequences, checked against a queue of predicted EX states.
module tb_id_ex_register;

    localparam int W       = 32;
    localparam int CW      = 2;
    localparam int CNT_MAX = 3;

    typedef struct {
        logic        regdst, alusrc, memtoreg, regwrite;
        logic        memread, memwrite, branch, jump;
        logic [1:0]  aluop;
        logic        valid;
        logic [31:0] pc4, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct, opcode;
    } id_t;

    typedef struct {
        id_t id;
        bit  flush, hold, exp_stall, exp_vex;
        int  exp_cnt;
    } vec_t;

    typedef struct {
        id_t ex;
        int  cnt;
    } exp_t;

    logic clk, rst_n;
    logic RegDst_ID, ALUSrc_ID, MemtoReg_ID, RegWrite_ID, MemRead_ID, MemWrite_ID, Branch_ID, Jump_ID;
    logic [1:0] ALUOp_ID;
    logic Valid_ID;
    logic [W-1:0] PC4_ID, ReadData1_ID, ReadData2_ID, SignImm_ID;
    logic [4:0] Rs_ID, Rt_ID, Rd_ID;
    logic [5:0] Funct_ID, Opcode_ID;
    logic Flush, Hold;
    logic RegDst_EX, ALUSrc_EX, MemtoReg_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, Branch_EX, Jump_EX;
    logic [1:0] ALUOp_EX;
    logic Valid_EX;
    logic [W-1:0] PC4_EX, ReadData1_EX, ReadData2_EX, SignImm_EX;
    logic [4:0] Rs_EX, Rt_EX, Rd_EX;
    logic [5:0] Funct_EX, Opcode_EX;
    logic Stall;
    logic [CW-1:0] BubbleCount;

    id_ex_register #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegDst_ID(RegDst_ID), .ALUSrc_ID(ALUSrc_ID), .MemtoReg_ID(MemtoReg_ID),
        .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
        .Branch_ID(Branch_ID), .Jump_ID(Jump_ID), .ALUOp_ID(ALUOp_ID), .Valid_ID(Valid_ID),
        .PC4_ID(PC4_ID), .ReadData1_ID(ReadData1_ID), .ReadData2_ID(ReadData2_ID),
        .SignImm_ID(SignImm_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID),
        .Funct_ID(Funct_ID), .Opcode_ID(Opcode_ID),
        .Flush(Flush), .Hold(Hold),
        .RegDst_EX(RegDst_EX), .ALUSrc_EX(ALUSrc_EX), .MemtoReg_EX(MemtoReg_EX),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .Branch_EX(Branch_EX), .Jump_EX(Jump_EX), .ALUOp_EX(ALUOp_EX), .Valid_EX(Valid_EX),
        .PC4_EX(PC4_EX), .ReadData1_EX(ReadData1_EX), .ReadData2_EX(ReadData2_EX),
        .SignImm_EX(SignImm_EX), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX),
        .Funct_EX(Funct_EX), .Opcode_EX(Opcode_EX),
        .Stall(Stall), .BubbleCount(BubbleCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   pc_seq   = 0;
    id_t  m_ex;
    int   m_cnt;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic id_t zero_id();
        id_t d;
        d = '{default: '0};
        return d;
    endfunction

    function automatic id_t clr_ctrl(input id_t d);
        id_t r;
        r = d;
        r.regdst = 0; r.alusrc = 0; r.memtoreg = 0; r.regwrite = 0;
        r.memread = 0; r.memwrite = 0; r.branch = 0; r.jump = 0;
        r.aluop = 2'b00; r.valid = 0;
        return r;
    endfunction

    function automatic id_t rtype(input logic [4:0] rs, rt, rd, input logic [31:0] a, b);
        id_t d;
        d = zero_id();
        d.valid = 1; d.regdst = 1; d.regwrite = 1; d.aluop = 2'b10;
        d.rs = rs; d.rt = rt; d.rd = rd; d.rd1 = a; d.rd2 = b;
        d.funct = 6'h20; d.opcode = 6'h00;
        return d;
    endfunction

    function automatic id_t itype(input logic [5:0] op, input logic [4:0] rs, rt);
        id_t d;
        d = zero_id();
        d.valid = 1; d.alusrc = 1; d.opcode = op;
        d.rs = rs; d.rt = rt; d.imm = 32'h0000_0010; d.rd1 = 32'h100; d.rd2 = 32'h55;
        if (op == 6'h23) begin d.memread = 1; d.memtoreg = 1; d.regwrite = 1; end
        if (op == 6'h2b) d.memwrite = 1;
        if (op == 6'h08) d.regwrite = 1;
        return d;
    endfunction

    task automatic drive(input id_t d);
        RegDst_ID = d.regdst; ALUSrc_ID = d.alusrc; MemtoReg_ID = d.memtoreg;
        RegWrite_ID = d.regwrite; MemRead_ID = d.memread; MemWrite_ID = d.memwrite;
        Branch_ID = d.branch; Jump_ID = d.jump; ALUOp_ID = d.aluop; Valid_ID = d.valid;
        PC4_ID = d.pc4; ReadData1_ID = d.rd1; ReadData2_ID = d.rd2; SignImm_ID = d.imm;
        Rs_ID = d.rs; Rt_ID = d.rt; Rd_ID = d.rd; Funct_ID = d.funct; Opcode_ID = d.opcode;
    endtask

    // Reference behaviour of one clock edge, applied to the bench's own EX state.
    task automatic model_edge(input id_t d, input bit fl, input bit hd);
        bit haz;
        haz = m_ex.valid && m_ex.memread && (m_ex.rt != 0) && d.valid &&
              ((m_ex.rt == d.rs) || ((m_ex.rt == d.rt) && (!d.alusrc || d.memwrite)));
        if (fl) m_ex = clr_ctrl(d);
        else if (hd) begin end
        else if (haz) begin
            m_ex  = clr_ctrl(d);
            m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end else m_ex = d.valid ? d : clr_ctrl(d);
    endtask

    task automatic compare_ex(input string tag, input exp_t e);
        check({tag, "_ctrl"},
              {RegDst_EX, ALUSrc_EX, MemtoReg_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, Branch_EX, Jump_EX, ALUOp_EX, Valid_EX},
              {e.ex.regdst, e.ex.alusrc, e.ex.memtoreg, e.ex.regwrite, e.ex.memread, e.ex.memwrite, e.ex.branch, e.ex.jump, e.ex.aluop, e.ex.valid});
        check({tag, "_pc4"}, PC4_EX, e.ex.pc4);
        check({tag, "_rd1"}, ReadData1_EX, e.ex.rd1);
        check({tag, "_rd2"}, ReadData2_EX, e.ex.rd2);
        check({tag, "_imm"}, SignImm_EX, e.ex.imm);
        check({tag, "_regs"}, {Rs_EX, Rt_EX, Rd_EX, Funct_EX, Opcode_EX},
              {e.ex.rs, e.ex.rt, e.ex.rd, e.ex.funct, e.ex.opcode});
        check({tag, "_cnt"}, BubbleCount, e.cnt);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            compare_ex(tag, e);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        id_t d;
        d = v.id;
        d.pc4 = 32'h0040_0000 + 32'(pc_seq * 4);
        pc_seq++;
        @(negedge clk);
        drive(d);
        Flush = v.flush;
        Hold  = v.hold;
        #1;
        check({tag, "_stall"}, Stall, v.exp_stall);
        model_edge(d, v.flush, v.hold);
        sb.push_back('{ex: m_ex, cnt: m_cnt});
        @(posedge clk);
        #1;
        check({tag, "_vex"}, Valid_EX, v.exp_vex);
        check({tag, "_cnt_tbl"}, BubbleCount, v.exp_cnt);
        pop_compare(tag);
    endtask

    function automatic vec_t mkv(input id_t d, input bit fl, hd, st, vx, input int c);
        vec_t v;
        v.id = d; v.flush = fl; v.hold = hd; v.exp_stall = st; v.exp_vex = vx; v.exp_cnt = c;
        return v;
    endfunction

    vec_t tbl[20];
    exp_t zero_exp;
    int   sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        id_t r, inv, ld2, add2;

        zero_exp.ex  = zero_id();
        zero_exp.cnt = 0;
        Flush = 0; Hold = 0;
        rst_n = 1'b0;

        // Reset held across three edges with live ID inputs.
        r = rtype(5'd1, 5'd2, 5'd3, 32'hDEADBEEF, 32'h1);
        drive(r);
        repeat (3) begin
            @(posedge clk); #1;
            compare_ex("rst_hold", zero_exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ex = zero_id(); m_cnt = 0;
        #1;
        model_edge(r, 0, 0);
        sb.push_back('{ex: m_ex, cnt: m_cnt});
        @(posedge clk); #1;
        pop_compare("rst_capture");
        // Mid-cycle asynchronous reset.
        #2 rst_n = 1'b0;
        #1 compare_ex("rst_async", zero_exp);
        @(negedge clk);
        rst_n = 1'b1;
        m_ex = zero_id(); m_cnt = 0;

        inv = rtype(5'd7, 5'd4, 5'd9, 32'h11, 32'h22);
        inv.valid = 0;
        inv.branch = 1;
        tbl[0]  = mkv(rtype(5'd1, 5'd2, 5'd3, 32'd5, 32'd7), 0, 0, 0, 1, 0);
        tbl[1]  = mkv(itype(6'h23, 5'd1, 5'd2), 0, 0, 0, 1, 0);
        tbl[2]  = mkv(rtype(5'd2, 5'd4, 5'd3, 32'h8, 32'h9), 0, 0, 1, 0, 1);
        tbl[3]  = mkv(rtype(5'd2, 5'd4, 5'd3, 32'h8, 32'h9), 0, 0, 0, 1, 1);
        tbl[4]  = mkv(itype(6'h23, 5'd1, 5'd0), 0, 0, 0, 1, 1);
        tbl[5]  = mkv(rtype(5'd0, 5'd0, 5'd6, 32'h0, 32'h0), 0, 0, 0, 1, 1);
        tbl[6]  = mkv(itype(6'h23, 5'd1, 5'd5), 0, 0, 0, 1, 1);
        tbl[7]  = mkv(itype(6'h08, 5'd1, 5'd5), 0, 0, 0, 1, 1);
        tbl[8]  = mkv(itype(6'h23, 5'd1, 5'd5), 0, 0, 0, 1, 1);
        tbl[9]  = mkv(itype(6'h2b, 5'd1, 5'd5), 0, 0, 1, 0, 2);
        tbl[10] = mkv(itype(6'h2b, 5'd1, 5'd5), 0, 0, 0, 1, 2);
        tbl[11] = mkv(itype(6'h23, 5'd1, 5'd2), 0, 0, 0, 1, 2);
        tbl[12] = mkv(rtype(5'd2, 5'd4, 5'd3, 32'h3, 32'h4), 1, 0, 0, 0, 2);
        tbl[13] = mkv(itype(6'h23, 5'd1, 5'd7), 0, 0, 0, 1, 2);
        tbl[14] = mkv(rtype(5'd7, 5'd4, 5'd8, 32'hA, 32'hB), 0, 1, 0, 1, 2);
        tbl[15] = mkv(rtype(5'd7, 5'd4, 5'd8, 32'hA, 32'hB), 0, 1, 0, 1, 2);
        tbl[16] = mkv(rtype(5'd7, 5'd4, 5'd8, 32'hA, 32'hB), 0, 1, 0, 1, 2);
        tbl[17] = mkv(rtype(5'd7, 5'd4, 5'd8, 32'hA, 32'hB), 0, 0, 1, 0, 3);
        tbl[18] = mkv(rtype(5'd7, 5'd4, 5'd8, 32'hA, 32'hB), 0, 0, 0, 1, 3);
        tbl[19] = mkv(inv, 0, 0, 0, 0, 3);

        for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("v%0d", i));

        // Saturation: five load-use bubbles on a 2-bit counter.
        @(negedge clk);
        Flush = 0; Hold = 0;
        rst_n = 1'b0;
        #1 compare_ex("sat_rst", zero_exp);
        rst_n = 1'b1;
        m_ex = zero_id(); m_cnt = 0;
        ld2  = itype(6'h23, 5'd1, 5'd2);
        add2 = rtype(5'd2, 5'd3, 5'd4, 32'h1, 32'h2);
        for (int i = 0; i < 5; i++) begin
            apply(mkv(ld2, 0, 0, 0, 1, (i == 0) ? 0 : sat_exp[i-1]), $sformatf("sat_ld%0d", i));
            apply(mkv(add2, 0, 0, 1, 0, sat_exp[i]), $sformatf("sat_bub%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register of the MIPS pipeline, directly downstream of the decode-stage control unit. Each cycle it latches the decoded control bundle (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Jump) and the decode-stage operands into the EX stage. It also contains load-use hazard detection: on a hazard it inserts a bubble and asserts Stall to freeze PC and IF/ID. It honours a branch/jump Flush and a global Hold, and counts inserted bubbles for performance debug.

## Interface

- WIDTH, 32, datapath width (operands, PC+4, immediate)
- CNT_W, 16, width of the bubble counter
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- RegDst_ID, ALUSrc_ID, MemtoReg_ID, RegWrite_ID, MemRead_ID, MemWrite_ID, Branch_ID, Jump_ID  in  1 each  control-unit outputs
- ALUOp_ID  in  2  control-unit ALUOp
- Valid_ID  in  1  IF/ID holds a real instruction (0 = bubble)
- PC4_ID, ReadData1_ID, ReadData2_ID, SignImm_ID  in  WIDTH  decode operands
- Rs_ID, Rt_ID, Rd_ID  in  5  register specifiers
- Funct_ID  in  6  instruction[5:0]; Opcode_ID  in  6  instruction[31:26]
- Flush  in  1  branch taken or jump resolved; squash the instruction entering EX
- Hold  in  1  global freeze (downstream memory stall)
- *_EX outputs  out  same widths  registered copies of every *_ID input above, plus Valid_EX
- Stall  out  1  combinational; freeze PC and IF/ID this cycle
- BubbleCount  out  CNT_W  saturating count of inserted bubbles

## Operation

- Control group = the 9 control fields plus Valid. Data group = PC4, ReadData1/2, SignImm, Rs, Rt, Rd, Funct, Opcode.
- Hazard (combinational): Haz = Valid_EX & MemRead_EX & (Rt_EX != 0) & Valid_ID & ((Rt_EX == Rs_ID) | ((Rt_EX == Rt_ID) & (~ALUSrc_ID | MemWrite_ID))).
- Stall = Haz & ~Flush & ~Hold.
- Per-edge action, priority high to low:
  - Flush: control group cleared to 0 and data group loaded from ID. Hold is ignored. The counter is not incremented.
  - Hold: all registers, including the counter, keep their value.
  - Haz (bubble): control group cleared to 0, data group loaded from ID, BubbleCount += 1 saturating at 2^CNT_W−1.
  - Normal: all fields loaded from ID.
- When Valid_ID=0, control group is loaded as 0 regardless of the *_ID control values.
- Don't-care (x) control fields from the control unit are latched unchanged. RegWrite, MemRead, MemWrite, Branch and Jump are never x when Valid_ID=1.
- Reset value of every output register, and of BubbleCount, is 0. The reset state is therefore a NOP bubble in EX.

## Timing

- Latency: one cycle from ID inputs to EX outputs. All *_EX outputs come straight from flops with no output logic.
- Stall is valid in the same cycle the hazard is present. The bench samples it before the rising edge.
- A load-use hazard gives exactly one bubble. On the next edge the load has left EX, so Haz drops unless a new load is in EX.
- Flush together with Haz in the same cycle: Flush wins, Stall=0, no count.
- Hold together with Haz: Stall=0. The hazard is re-evaluated after Hold drops.
- rst_n assertion mid-operation clears all flops immediately, asynchronously. The first capture happens on the first rising edge after rst_n deasserts.
- BubbleCount at saturation: it stays at its maximum and never wraps.

## Test plan

- Reset: drive ID inputs with RegWrite_ID=1 and ReadData1_ID=0xDEADBEEF, hold rst_n=0 across 3 edges, then pulse rst_n low mid-cycle → every *_EX output and BubbleCount read 0, both during reset and immediately on assertion.
- Pass-through: R-type ADD with Rs=1, Rt=2, Rd=3, RD1=5, RD2=7, ALUOp=10, RegDst=1, RegWrite=1 → one edge later the *_EX outputs match exactly, and Stall=0 throughout.
- Load-use: lw $2 in EX (MemRead_EX=1, Rt_EX=2), ID has add $3,$2,$4 → Stall=1. Next edge: control_EX=0, BubbleCount=1. Following edge with the same ID: add is captured and Stall=0. A load into $0 produces no stall.
- Rt rule: lw $5 in EX, ID has addi $6,$5-free (Rs=1, Rt=5, ALUSrc=1) → Stall=0. Then sw with Rt=5 (MemWrite=1) → Stall=1.
- Priority: Flush=1 together with the load-use hazard → Stall=0, control_EX=0 next edge, counter unchanged. Hold=1 for 3 edges → outputs frozen and counter frozen.
- Saturation: with CNT_W=2, force 5 consecutive bubbles → BubbleCount goes 1, 2, 3, 3, 3.
